// File: rtl/spad_seq_ctrl.sv
// Kernel-row scratchpad sequencer: steers load beats into FIFO lines, then
// drains the lines column by column and flags each complete column.
module spad_seq_ctrl #(
   parameter int KERNEL_SIZE    = 5,
   parameter int FEATURE_WIDTH  = 16,
   parameter int DATA_BUS_WIDTH = 128,
   parameter int BEATS_PER_LINE = 1,
   parameter int RD_LAT         = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_BUS_WIDTH-1:0] in_data,
   output logic                      spad_wr_en,
   output logic [3:0]                spad_wr_line,
   output logic [DATA_BUS_WIDTH-1:0] spad_wr_data,
   output logic                      spad_rd_en,
   output logic [3:0]                spad_rd_line,
   input  logic                      spad_group_empty,
   input  logic                      spad_group_full,
   output logic                      col_valid,
   output logic                      busy,
   output logic                      done
);

   localparam int ELEMS  = BEATS_PER_LINE * DATA_BUS_WIDTH / FEATURE_WIDTH;
   localparam int BEAT_W = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
   localparam int ELEM_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

   localparam logic [3:0]        LAST_LINE = 4'(KERNEL_SIZE - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);
   localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(ELEMS - 1);
   localparam logic [RD_LAT-1:0] PIPE_TOP  = RD_LAT'(1) << (RD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN,
      S_FLUSH
   } state_e;

   state_e              state_q,    state_d;
   logic [3:0]          line_cnt_q, line_cnt_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [ELEM_W-1:0]   elem_cnt_q, elem_cnt_d;
   logic [RD_LAT-1:0]   col_pipe_q, col_pipe_d;
   logic                col_issue;

   // NOTE: synchronous reset lives inside the clocked block; state updates use <= only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         line_cnt_q <= '0;
         beat_cnt_q <= '0;
         elem_cnt_q <= '0;
         col_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         line_cnt_q <= line_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         elem_cnt_q <= elem_cnt_d;
         col_pipe_q <= col_pipe_d;
      end
   end

   assign spad_wr_data = in_data;
   assign busy         = (state_q != S_IDLE);
   assign col_valid    = col_pipe_q[RD_LAT-1];

   // The final column leaves the pipe with nothing queued behind it.
   assign done = (state_q == S_FLUSH) && col_valid && ((col_pipe_q & ~PIPE_TOP) == '0);

   // Shift toward the output every cycle; truncation drops the bit just emitted.
   assign col_pipe_d = RD_LAT'({col_pipe_q, col_issue});

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d      = state_q;
      line_cnt_d   = line_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      elem_cnt_d   = elem_cnt_q;
      in_ready     = 1'b0;
      spad_wr_en   = 1'b0;
      spad_wr_line = '0;
      spad_rd_en   = 1'b0;
      spad_rd_line = '0;
      col_issue    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FILL;
               line_cnt_d = '0;
               beat_cnt_d = '0;
               elem_cnt_d = '0;
            end
         end

         S_FILL: begin
            in_ready     = !spad_group_full;
            spad_wr_line = line_cnt_q;
            if (in_valid && !spad_group_full) begin
               spad_wr_en = 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d = '0;
                  if (line_cnt_q == LAST_LINE) begin
                     line_cnt_d = '0;
                     state_d    = S_DRAIN;
                  end else begin
                     line_cnt_d = line_cnt_q + 4'd1;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end

         S_DRAIN: begin
            spad_rd_line = line_cnt_q;
            if (!spad_group_empty) begin
               spad_rd_en = 1'b1;
               if (line_cnt_q == LAST_LINE) begin
                  line_cnt_d = '0;
                  col_issue  = 1'b1;
                  if (elem_cnt_q == LAST_ELEM) begin
                     elem_cnt_d = '0;
                     state_d    = S_FLUSH;
                  end else begin
                     elem_cnt_d = elem_cnt_q + 1'b1;
                  end
               end else begin
                  line_cnt_d = line_cnt_q + 4'd1;
               end
            end
         end

         S_FLUSH: begin
            if (done) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_spad_seq_ctrl.sv
// Randomized bench for spad_seq_ctrl, checked against a transaction-count
// model of a fill/drain pass plus per-pass totals and latency checks.
module tb_spad_seq_ctrl;

   localparam int K      = 5;
   localparam int FW     = 16;
   localparam int DBW    = 128;
   localparam int BPL    = 1;
   localparam int RD_LAT = 1;
   localparam int ELEMS  = BPL * DBW / FW;
   localparam int N_WR   = K * BPL;
   localparam int N_RD   = K * ELEMS;

   localparam int P_IDLE = 0, P_FILL = 1, P_DRAIN = 2, P_FLUSH = 3;
   localparam int M_RANDOM = 0, M_GAPPED = 1, M_FULL3 = 2, M_EMPTY4 = 3, M_RST = 4;

   logic           clk = 1'b0;
   logic           rst, start, in_valid, in_ready;
   logic [DBW-1:0] in_data, spad_wr_data;
   logic           spad_wr_en, spad_rd_en;
   logic [3:0]     spad_wr_line, spad_rd_line;
   logic           spad_group_empty, spad_group_full;
   logic           col_valid, busy, done;

   spad_seq_ctrl #(
      .KERNEL_SIZE   (K),
      .FEATURE_WIDTH (FW),
      .DATA_BUS_WIDTH(DBW),
      .BEATS_PER_LINE(BPL),
      .RD_LAT        (RD_LAT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .spad_wr_en      (spad_wr_en),
      .spad_wr_line    (spad_wr_line),
      .spad_wr_data    (spad_wr_data),
      .spad_rd_en      (spad_rd_en),
      .spad_rd_line    (spad_rd_line),
      .spad_group_empty(spad_group_empty),
      .spad_group_full (spad_group_full),
      .col_valid       (col_valid),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string tag, input logic [DBW-1:0] act, input logic [DBW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a pass is N_WR accepted beats, then N_RD reads in
   // column order, each finished column showing up RD_LAT cycles later.
   int m_phase = P_IDLE;
   int m_wr, m_rd;
   int due[$];
   bit e_ready, e_acc, e_rd, e_col, e_done;

   int pass_wr, pass_rd, pass_col, pass_done;
   int last_wr_cyc, first_rd_cyc, first_col_cyc, last_col_cyc, done_cyc;

   always @(negedge clk) begin
      if (chk_en) begin
         e_ready = (m_phase == P_FILL) && !spad_group_full;
         e_acc   = e_ready && in_valid;
         e_rd    = (m_phase == P_DRAIN) && !spad_group_empty;
         e_col   = 1'b0;
         if (due.size() > 0) begin
            if (due[0] == cyc) begin
               e_col = 1'b1;
               void'(due.pop_front());
            end
         end
         e_done = e_col && (due.size() == 0) && (m_phase == P_FLUSH);

         check("in_ready",   DBW'(in_ready),   DBW'(e_ready));
         check("spad_wr_en", DBW'(spad_wr_en), DBW'(e_acc));
         check("spad_rd_en", DBW'(spad_rd_en), DBW'(e_rd));
         check("col_valid",  DBW'(col_valid),  DBW'(e_col));
         check("done",       DBW'(done),       DBW'(e_done));
         check("busy",       DBW'(busy),       DBW'(m_phase != P_IDLE));
         if (e_acc) begin
            check("spad_wr_line", DBW'(spad_wr_line), DBW'(m_wr / BPL));
            check("spad_wr_data", spad_wr_data, in_data);
         end
         if (e_rd) check("spad_rd_line", DBW'(spad_rd_line), DBW'(m_rd % K));
         if (m_phase == P_IDLE) begin
            check("idle_wr_line", DBW'(spad_wr_line), DBW'(0));
            check("idle_rd_line", DBW'(spad_rd_line), DBW'(0));
         end

         if (spad_wr_en === 1'b1) begin pass_wr++; last_wr_cyc = cyc; end
         if (spad_rd_en === 1'b1) begin
            if (pass_rd == 0) first_rd_cyc = cyc;
            pass_rd++;
         end
         if (col_valid === 1'b1) begin
            if (pass_col == 0) first_col_cyc = cyc;
            last_col_cyc = cyc;
            pass_col++;
         end
         if (done === 1'b1) begin pass_done++; done_cyc = cyc; end

         if (rst) begin
            m_phase = P_IDLE;
            due.delete();
         end else begin
            case (m_phase)
               P_IDLE: if (start) begin
                  m_phase = P_FILL;
                  m_wr = 0; m_rd = 0;
                  pass_wr = 0; pass_rd = 0; pass_col = 0; pass_done = 0;
                  last_wr_cyc = -1; first_rd_cyc = -1;
                  first_col_cyc = -1; last_col_cyc = -1; done_cyc = -1;
               end
               P_FILL: if (e_acc) begin
                  m_wr++;
                  if (m_wr == N_WR) m_phase = P_DRAIN;
               end
               P_DRAIN: if (e_rd) begin
                  if (m_rd % K == K - 1) due.push_back(cyc + RD_LAT);
                  m_rd++;
                  if (m_rd == N_RD) m_phase = P_FLUSH;
               end
               default: if (e_done) m_phase = P_IDLE;
            endcase
         end
      end
      cyc++;
   end

   task automatic run_pass(input int mode, input int valid_pct, input int full_pct,
                           input int empty_pct, input bit spam);
      int  budget;
      int  full_left;
      int  empty_left;
      bit  gap;
      bit  unstalled;
      rst              = 1'b0;
      start            = 1'b1;
      in_valid         = 1'b0;
      spad_group_full  = 1'b0;
      spad_group_empty = 1'b0;
      tick();
      start      = 1'b0;
      budget     = 0;
      full_left  = 3;
      empty_left = 4;
      gap        = 1'b0;
      unstalled  = (empty_pct == 0) && (mode != M_EMPTY4);
      while (m_phase != P_IDLE && budget < 3000) begin
         rst     = 1'b0;
         in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         start   = spam && (m_phase == P_FILL || m_phase == P_DRAIN) && ($urandom_range(99) < 20);
         if (mode == M_GAPPED) begin
            in_valid = gap;
            gap      = !gap;
         end else begin
            in_valid = ($urandom_range(99) < valid_pct);
         end
         spad_group_full  = ($urandom_range(99) < full_pct);
         spad_group_empty = (m_phase == P_DRAIN) && ($urandom_range(99) < empty_pct);
         if (mode == M_FULL3 && m_phase == P_FILL && m_wr == 2 && full_left > 0) begin
            spad_group_full = 1'b1;
            in_valid        = 1'b1;
            full_left--;
         end
         if (mode == M_EMPTY4 && m_phase == P_DRAIN && m_rd == 2 * K + 2 && empty_left > 0) begin
            spad_group_empty = 1'b1;
            empty_left--;
         end
         if (mode == M_RST && m_phase == P_DRAIN && m_rd == 3 * K) rst = 1'b1;
         tick();
         budget++;
      end
      rst              = 1'b0;
      start            = 1'b0;
      in_valid         = 1'b0;
      spad_group_full  = 1'b0;
      spad_group_empty = 1'b0;
      check("pass_in_budget", DBW'(budget < 3000), DBW'(1));
      if (mode != M_RST) begin
         check("pass_writes", DBW'(pass_wr),   DBW'(N_WR));
         check("pass_reads",  DBW'(pass_rd),   DBW'(N_RD));
         check("pass_cols",   DBW'(pass_col),  DBW'(ELEMS));
         check("pass_dones",  DBW'(pass_done), DBW'(1));
         check("done_with_last_col", DBW'(done_cyc), DBW'(last_col_cyc));
         if (unstalled) begin
            check("fill_to_drain",  DBW'(first_rd_cyc - last_wr_cyc),  DBW'(1));
            check("first_col_off",  DBW'(first_col_cyc - first_rd_cyc), DBW'(K - 1 + RD_LAT));
            check("last_col_off",   DBW'(last_col_cyc - first_rd_cyc),  DBW'(N_RD - 1 + RD_LAT));
         end
      end
   endtask

   initial begin
      rst              = 1'b1;
      start            = 1'b0;
      in_valid         = 1'b0;
      in_data          = '0;
      spad_group_full  = 1'b0;
      spad_group_empty = 1'b0;
      repeat (2) tick();
      rst    = 1'b0;
      chk_en = 1'b1;
      repeat (2) tick();

      run_pass(M_RANDOM, 100, 0, 0, 1'b0);
      run_pass(M_GAPPED,   0, 0, 0, 1'b0);
      run_pass(M_FULL3,  100, 0, 0, 1'b0);
      run_pass(M_EMPTY4, 100, 0, 0, 1'b0);
      run_pass(M_RST,    100, 0, 0, 1'b0);
      run_pass(M_RANDOM, 100, 0, 0, 1'b0);
      run_pass(M_RANDOM, 100, 0, 0, 1'b1);

      for (int p = 0; p < 20; p++) begin
         run_pass(M_RANDOM, $urandom_range(30, 100), $urandom_range(0, 40),
                  $urandom_range(0, 40), 1'($urandom_range(0, 1)));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            in_valid        = 1'($urandom_range(0, 1));
            spad_group_full = 1'($urandom_range(0, 1));
            tick();
         end
         in_valid        = 1'b0;
         spad_group_full = 1'b0;
      end

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spad_seq_ctrl.md
# spad_seq_ctrl

Sequencer for the kernel-row scratchpad memory in the feature-load path. It accepts a burst of feature words from the load stream and steers each row into its FIFO line, then drains every line element by element in column order. It emits a column-valid strobe each time a full KERNEL_SIZE-tall column is present on the scratchpad output bus. It sits between the feature-load DMA stream and the scratchpad, and drives all of the scratchpad's write/read line indices and enables.

## Interface
- KERNEL_SIZE, 5, number of scratchpad FIFO lines (rows per window); max 15
- FEATURE_WIDTH, 16, bits per feature element
- DATA_BUS_WIDTH, 128, bits per load beat
- BEATS_PER_LINE, 1, load beats per row
- RD_LAT, 1, scratchpad FIFO read latency in cycles (rd_en to dout)
- ELEMS (derived), BEATS_PER_LINE*DATA_BUS_WIDTH/FEATURE_WIDTH, elements per row
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a fill/drain pass; honoured only in IDLE
- in_valid  in  1  load beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  DATA_BUS_WIDTH  load beat
- spad_wr_en  out  1  scratchpad write enable
- spad_wr_line  out  4  target line for write
- spad_wr_data  out  DATA_BUS_WIDTH  in_data forwarded combinationally
- spad_rd_en  out  1  scratchpad read enable
- spad_rd_line  out  4  line being read
- spad_group_empty  in  1  scratchpad line-0 empty
- spad_group_full  in  1  scratchpad last-line full
- col_valid  out  1  scratchpad data_out holds one complete column
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the pass ends

## Operation
- States: IDLE, FILL, DRAIN, FLUSH.
- IDLE: on start, go to FILL; clear line_cnt, beat_cnt, elem_cnt.
- FILL: in_ready = !spad_group_full. Each accepted beat drives spad_wr_en=1 and spad_wr_line=line_cnt in the same cycle, and increments beat_cnt.
  - When beat_cnt wraps at BEATS_PER_LINE, line_cnt increments.
  - After the last beat of line KERNEL_SIZE-1, go to DRAIN.
- DRAIN: each cycle with !spad_group_empty, assert spad_rd_en=1 with spad_rd_line=line_cnt, then advance line_cnt 0..KERNEL_SIZE-1.
  - When line_cnt wraps, elem_cnt increments.
  - Cycles with spad_group_empty=1 drive spad_rd_en=0 and hold both counters.
- Issuing the read of line KERNEL_SIZE-1 schedules col_valid exactly RD_LAT cycles later, through an RD_LAT-deep shift register.
- After the read of line KERNEL_SIZE-1 at elem_cnt=ELEMS-1, go to FLUSH.
- FLUSH: wait until the col_valid pipe is empty. Pulse done together with the final col_valid, then go to IDLE.
- start outside IDLE is ignored. in_ready=0 outside FILL, so in_valid is ignored there.
- Counter widths: line_cnt 4 bits; beat_cnt and elem_cnt clog2 of their bound, minimum 1 bit.

## Timing
- Reset values: state=IDLE; in_ready, spad_wr_en, spad_rd_en, col_valid, busy, done all 0; spad_wr_line and spad_rd_line 0; counters and col_valid pipe cleared.
- Reset mid-pass: the next cycle is IDLE with all outputs at reset values and no further enables. The scratchpad shares rst, so no partial data survives.
- Latencies:
  - start to FILL (in_ready=1): 1 cycle.
  - Beat accept to spad_wr_en: 0 cycles (combinational).
  - Last accepted beat to first spad_rd_en: 1 cycle.
- Unstalled drain: KERNEL_SIZE*ELEMS cycles of reads, then RD_LAT cycles of FLUSH. busy drops the cycle after done.
- Simultaneous in_valid and spad_group_full: no accept, no write, counters hold.

## Test plan
- Defaults, start, then 5 back-to-back beats: spad_wr_line 0,1,2,3,4 on consecutive cycles; DRAIN begins the next cycle; 40 spad_rd_en pulses with spad_rd_line cycling 0..4 eight times; 8 col_valid pulses, first at drain cycle 5 and last at drain cycle 40; done at drain cycle 40; busy=0 at cycle 41.
- in_valid gapped every other cycle: writes occur only on accepted beats, and the line order stays 0..4.
- spad_group_full=1 for 3 cycles during FILL: in_ready=0 and no writes for those cycles; line_cnt unchanged; the pass completes with 5 writes total.
- spad_group_empty=1 for 4 cycles mid-DRAIN at line 2: spad_rd_en=0 for those cycles; resumes at line 2; still exactly 40 reads and 8 col_valid.
- rst asserted during DRAIN at elem 3: next cycle state=IDLE with all outputs 0; a second start in the next cycle runs a full clean pass.
- start pulsed during FILL and DRAIN: no effect; exactly one done per pass.
